// File: rtl/bcd_to_bin_seq.sv
// rtl/bcd_to_bin_seq.sv - sequential reverse double-dabble BCD-to-binary converter
module bcd_to_bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14,
  parameter int CW     = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]            state;
  logic [4*DIGITS-1:0]   bcd_reg;
  logic [4*DIGITS-1:0]   bcd_next;
  logic [BIN_W-1:0]      bin_reg;
  logic [BIN_W-1:0]      bin_next;
  logic [CW-1:0]         cnt;
  logic                  bad_digit;

  function automatic logic any_bad(input logic [4*DIGITS-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // A digit that received a shifted-in 1 from its upper neighbour gained 8 instead of 5.
  function automatic logic [4*DIGITS-1:0] fix_digits(input logic [4*DIGITS-1:0] v);
    logic [4*DIGITS-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd8) r[4*i +: 4] = v[4*i +: 4] - 4'd3;
    end
    return r;
  endfunction

  always_comb begin
    bad_digit = any_bad(bcd_in);
    bcd_next  = fix_digits({1'b0, bcd_reg[4*DIGITS-1:1]});
    bin_next  = {bcd_reg[0], bin_reg[BIN_W-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      bcd_reg <= '0;
      bin_reg <= '0;
      cnt     <= '0;
      bin_out <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (bad_digit) begin
              err     <= 1'b1;
              bin_out <= '0;
              state   <= DONE;
            end else begin
              bcd_reg <= bcd_in;
              bin_reg <= '0;
              cnt     <= '0;
              state   <= CONV;
            end
          end
        end
        CONV: begin
          bin_reg <= bin_next;
          bcd_reg <= bcd_next;
          cnt     <= cnt + 1'b1;
          if (cnt == CW'(BIN_W - 1)) begin
            bin_out <= bin_next;
            err     <= 1'b0;
            state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == CONV);
  assign out_valid = (state == DONE);

endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
- Sequential multi-digit BCD-to-binary converter. It is the inverse companion of the team's combinational binary-to-BCD converter.
- Accepts one packed BCD word per transaction over a valid/ready handshake.
- Converts using reverse double-dabble: shift right one bit per clock, then subtract 3 from any BCD digit >= 8.
- Presents the binary result on a held valid/ready output. Sits between keypad/display-side BCD logic and binary arithmetic datapaths.

Parameters:
- DIGITS, 4, number of packed BCD digits on bcd_in.
- BIN_W, 14, binary result width. Must satisfy 2^BIN_W > 10^DIGITS - 1. Also equals the number of conversion iterations.
- CW, 4, iteration counter width. Must satisfy 2^CW > BIN_W.

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  synchronous, active-low reset.
- bcd_in  input  4*DIGITS  packed BCD; digit 0 is in bits [3:0].
- in_valid  input  1  bcd_in is valid.
- in_ready  output  1  block can accept a word.
- bin_out  output  BIN_W  binary result.
- err  output  1  accepted word contained a digit > 9.
- out_valid  output  1  bin_out/err are valid.
- out_ready  input  1  downstream accepts result.
- busy  output  1  conversion in progress.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (resetn), sampled on the rising edge of clk.
- Reset (resetn=0 at an edge): state=IDLE, in_ready=1, out_valid=0, busy=0, err=0, bin_out=0, internal BCD register=0, counter=0.
- Reset overrides everything. It aborts a conversion in progress and discards a held result.
- States: IDLE, CONV, DONE.
- Control outputs by state:
  - in_ready=1 only in IDLE.
  - busy=1 only in CONV.
  - out_valid=1 only in DONE.
- Accept: an edge with state=IDLE and in_valid=1 is the accept edge N.
  - Every digit <= 9: load BCD register with bcd_in, clear the binary register, counter=0, go to CONV.
  - Any digit > 9: set err=1, bin_out=0, go directly to DONE; out_valid=1 after edge N.
- CONV iteration, one per clock:
  - bin_reg <= {bcd_reg[0], bin_reg[BIN_W-1:1]}.
  - bcd_reg is shifted right by 1 with 0 into the MSB.
  - Then each 4-bit digit of the shifted value that is >= 8 has 3 subtracted. All digits are corrected in parallel, combinationally within the same cycle.
- Termination:
  - The counter increments every CONV cycle.
  - The iteration with counter = BIN_W-1 is the last. At that edge (N+BIN_W): state <= DONE, bin_out <= final bin_reg, err <= 0.
  - Latency: out_valid first high in the cycle after edge N+BIN_W, i.e. BIN_W cycles after accept. Latency is fixed and independent of data value.
- DONE hold: bin_out and err stay stable while out_valid=1 and out_ready=0, for any number of cycles.
- Release: the edge with state=DONE and out_ready=1 moves to IDLE and clears out_valid. bin_out and err keep their last values until the next result loads.
- No accept can occur in the same cycle as release. Back-to-back throughput is one word per BIN_W+2 cycles minimum.
- Ignored inputs:
  - in_valid is ignored outside IDLE, and bcd_in changes outside IDLE have no effect.
  - out_ready is ignored outside DONE.
- Boundary values:
  - All-zero input yields bin_out=0, err=0 after the full BIN_W latency; there is no early exit.
  - Maximum input (all digits 9) yields 10^DIGITS-1 exactly.
  - After the final iteration bcd_reg is all zero. The bench checks this as an internal invariant.

Test Plan:
- Reset: assert resetn=0 for 2 cycles mid-CONV -> in_ready=1, out_valid=0, busy=0, bin_out=0, err=0 on the next cycle. No stale result appears afterwards.
- Basic value: bcd_in=16'h0255, in_valid pulse, out_ready=1 -> out_valid rises exactly 14 cycles after accept with bin_out=14'h00FF, err=0. It drops one cycle later.
- Extremes:
  - bcd_in=16'h9999 -> bin_out=14'h270F (9999).
  - bcd_in=16'h0000 -> bin_out=0 after 14 cycles.
  - bcd_in=16'h0001 -> 1.
- Invalid digit: bcd_in=16'h12A4 -> out_valid the cycle after accept, err=1, bin_out=0, busy never asserted. A following 16'h0010 gives bin_out=10, err=0.
- Backpressure: bcd_in=16'h4096, out_ready=0 for 20 cycles -> bin_out=14'h1000 held stable with out_valid=1 and in_ready=0 throughout. in_valid/bcd_in toggled meanwhile are ignored. out_ready=1 then releases in one cycle.
- Sweep: all values 0..9999 back-to-back with random out_ready stalls -> every bin_out equals the decimal value of its input, and each result has exactly 14 cycles of accept-to-valid latency.
